// File: rtl/ret_addr_stack_pkg.sv
// Shared CPU constants for the fetch path and the return-address stack.
package ret_addr_stack_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned WORD_LSB  = 2;
  localparam int unsigned RAS_DEPTH = 8;

  localparam int unsigned ENTRY_W   = ADDR_W - WORD_LSB;

endpackage : ret_addr_stack_pkg

// File: rtl/ret_addr_stack.sv
// Circular return-address stack: jal pushes the link address, jr $ra pops it.
// The top entry is read combinationally from state so next-PC sees it in-cycle.
module ret_addr_stack
  import ret_addr_stack_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [ADDR_W-1:0]   push_addr,
  input  logic                pop,
  input  logic                flush,
  output logic [ADDR_W-1:0]   top_addr,
  output logic                top_valid,
  output logic [PTR_W:0]      count,
  output logic                overflow,
  output logic                underflow
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   tp;
  logic [PTR_W-1:0]   tp_inc;
  logic [PTR_W-1:0]   tp_dec;
  logic [ENTRY_W-1:0] push_word;
  logic               is_empty;
  logic               is_full;

  // Pointer neighbours wrap naturally modulo DEPTH.
  assign tp_inc    = tp + PTR_W'(1);
  assign tp_dec    = tp - PTR_W'(1);
  assign push_word = push_addr[ADDR_W-1:WORD_LSB];
  assign is_empty  = (count == CNT_W'(0));
  assign is_full   = (count == CNT_W'(DEPTH));

  // Storage, pointer, count and single-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (flush) begin
        tp    <= '0;
        count <= '0;
      end else if (push && pop) begin
        if (!is_empty) begin
          mem[tp] <= push_word;
        end else begin
          mem[tp_inc] <= push_word;
          tp          <= tp_inc;
          count       <= CNT_W'(1);
          underflow   <= 1'b1;
        end
      end else if (push) begin
        mem[tp_inc] <= push_word;
        tp          <= tp_inc;
        if (is_full) begin
          overflow <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end else if (pop) begin
        if (!is_empty) begin
          tp    <= tp_dec;
          count <= count - CNT_W'(1);
        end else begin
          underflow <= 1'b1;
        end
      end
    end
  end

  // Top-of-stack view, forced to zero when nothing is live.
  assign top_valid = !is_empty;
  assign top_addr  = is_empty ? '0 : {mem[tp], WORD_LSB'(0)};

endmodule : ret_addr_stack

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
- Circular return-address stack for the single-cycle CPU fetch path; the return-side counterpart of the jump-target mux.
- A call (jal) pushes the link address. A return (jr $ra) pops it and supplies the predicted target to the next-PC selection.
- Storage is registered. The top-of-stack read is combinational from state, so the PC logic sees it in the same cycle.

Parameters:
- DEPTH, 8, number of entries; power of two, 2..64.
- PTR_W, $clog2(DEPTH), width of the top pointer (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  call retiring this cycle; store push_addr.
- push_addr  input  32  link address (PC+4); bits [1:0] ignored.
- pop  input  1  return retiring this cycle; remove top.
- flush  input  1  discard all entries (exception/mispredict).
- top_addr  output  32  current top entry, {mem[tp], 2'b00}; 0 when empty.
- top_valid  output  1  count != 0.
- count  output  PTR_W+1  live entry count, 0..DEPTH.
- overflow  output  1  registered one-cycle pulse: a push overwrote the oldest entry.
- underflow  output  1  registered one-cycle pulse: pop while empty.

Behaviour:
- Reset (async, rst_n low): tp=0, count=0, all mem entries=0, overflow=0, underflow=0. This gives top_addr=0 and top_valid=0 immediately, with no clock needed. Release is synchronous to the next clk edge.
- Storage: DEPTH x 30-bit array holding addr[31:2]. Output re-appends 2'b00, so the word-aligned invariant holds by construction.
- tp points at the current top; pointer arithmetic is modulo DEPTH (natural PTR_W wrap).
- Per-cycle priority: flush > (push & pop) > push > pop > idle.
- flush: count<=0, tp<=0; mem is unchanged; push/pop that cycle are ignored; overflow/underflow <=0.
- push only:
  - tp<=tp+1 and mem[tp+1]<=push_addr[31:2].
  - If count==DEPTH: count stays DEPTH and overflow<=1 (oldest entry lost by wrap).
  - Otherwise count<=count+1.
- pop only:
  - If count>0: tp<=tp-1, count<=count-1.
  - If count==0: no state change, underflow<=1.
- push & pop together (return immediately followed by a call):
  - If count>0: mem[tp]<=push_addr[31:2]; tp and count unchanged; no pulses.
  - If count==0: behave as push only (count<=1) and underflow<=1.
- overflow and underflow are cleared every cycle they are not set, so each is a single-cycle pulse.
- Latency:
  - Push visible on top_addr the cycle after the push edge.
  - Pop exposes the next-older entry the cycle after.
  - No bypass from push_addr to top_addr within the same cycle.
- Wrap: after more than DEPTH pushes, pops return the newest DEPTH entries in LIFO order. count then reaches 0 and top_valid falls, even though mem still holds stale data.
- Reset mid-operation: all state is cleared asynchronously. Any push or pop asserted during reset is dropped.

Decomposition:
- Shared cpu package:
  - ADDR_W=32 and WORD_LSB=2 constants.
  - RAS_DEPTH default constant, also used by the next-PC mux and the testbench.
- No sub-module is needed. The storage array and pointer/count logic sit in one always block plus combinational output assigns.
- A separate ras_ptr counter is not warranted at this size.

Test Plan:
- Reset: hold rst_n=0 mid-run with push=1 -> top_valid=0, count=0, top_addr=0 asynchronously; after release, first push of 0x0040_0010 gives top_addr=0x0040_0010 and count=1 next cycle.
- LIFO: push 0x100, 0x204, 0x308, then pop x3 -> top_addr shows 0x308, 0x204, 0x100, then 0 with top_valid=0; underflow never pulses.
- Alignment: push 0x0000_1237 -> top_addr=0x0000_1234.
- Overflow (DEPTH=8): push 0x1000+4*i for i=0..8 -> overflow pulses exactly on the 9th push and count=8. Eight pops then return 0x1020 down to 0x1004, after which top_valid=0.
- Simultaneous / underflow:
  - With top 0x500 and count=2, push=pop=1 with push_addr 0x600 -> top_addr=0x600, count=2.
  - With empty stack, pop -> underflow=1 for one cycle, count=0.
  - With empty stack, push=pop with 0x700 -> count=1, top_addr=0x700, underflow pulse.
- Flush priority: count=5, assert flush with push=1 (0x900) -> count=0, top_valid=0, top_addr=0, no overflow or underflow pulse.
